// File: rtl/s55dram_w64d1042.sv
// True dual-port synchronous SRAM model (DATA_WIDTH x DEPTH) standing in for the hard macro.
// Latency: read data registered on Q one clk edge after CEN=0/WEN=1; writes land on the same edge.
// Backpressure: none; every enabled port operation completes on its edge.
module s55dram_w64d1042 #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1042,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CENA,
    input  logic                  WENA,
    input  logic [ADDR_WIDTH-1:0] AA,
    input  logic [DATA_WIDTH-1:0] DA,
    output logic [DATA_WIDTH-1:0] QA,
    input  logic                  CENB,
    input  logic                  WENB,
    input  logic [ADDR_WIDTH-1:0] AB,
    input  logic [DATA_WIDTH-1:0] DB,
    output logic [DATA_WIDTH-1:0] QB
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic a_in_range;
    logic b_in_range;
    logic a_wr;
    logic b_wr;
    logic a_rd;
    logic b_rd;

    assign a_in_range = (AA <= LAST_ADDR);
    assign b_in_range = (AB <= LAST_ADDR);
    assign a_wr       = !CENA && !WENA && a_in_range;
    // Port A owns the word when both ports write the same address.
    assign b_wr       = !CENB && !WENB && b_in_range && !(a_wr && (AA == AB));
    assign a_rd       = !CENA && WENA;
    assign b_rd       = !CENB && WENB;

    // Array has no reset; only the output registers are cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (a_wr) begin
                mem[AA] <= DA;
            end
            if (b_wr) begin
                mem[AB] <= DB;
            end
        end
    end

    // Reads sample the array before this edge's writes land (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            QA <= '0;
        end else if (a_rd) begin
            QA <= a_in_range ? mem[AA] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            QB <= '0;
        end else if (b_rd) begin
            QB <= b_in_range ? mem[AB] : '0;
        end
    end

endmodule

// File: tb/tb_s55dram_w64d1042.sv
// Directed bench for s55dram_w64d1042 with a behavioural memory model and per-cycle output compare.
module tb_s55dram_w64d1042;

    localparam int DW    = 64;
    localparam int DEPTH = 1042;
    localparam int AW    = 11;

    logic          clk;
    logic          rst;
    logic          CENA, WENA, CENB, WENB;
    logic [AW-1:0] AA, AB;
    logic [DW-1:0] DA, DB, QA, QB;

    s55dram_w64d1042 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .CENA(CENA), .WENA(WENA), .AA(AA), .DA(DA), .QA(QA),
        .CENB(CENB), .WENB(WENB), .AB(AB), .DB(DB), .QB(QB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [DW-1:0] model_mem [DEPTH];
    bit            model_set [DEPTH];
    logic [DW-1:0] exp_qa, exp_qb;
    bit            known_a, known_b;

    int total_cnt;
    int pass_cnt;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (known_a) check("qa_model", QA, exp_qa);
        if (known_b) check("qb_model", QB, exp_qb);
    end

    // Apply one edge's worth of stimulus and advance the model by the same rules.
    task automatic step(input bit r,
                        input bit cena, input bit wena, input int aa, input logic [DW-1:0] da,
                        input bit cenb, input bit wenb, input int ab, input logic [DW-1:0] db);
        logic [DW-1:0] rd_a, rd_b;
        bit            ka, kb;
        rst  = r;
        CENA = cena; WENA = wena; AA = AW'(aa); DA = da;
        CENB = cenb; WENB = wenb; AB = AW'(ab); DB = db;
        rd_a = '0; rd_b = '0; ka = 1'b1; kb = 1'b1;
        if (aa < DEPTH) begin rd_a = model_mem[aa]; ka = model_set[aa]; end
        if (ab < DEPTH) begin rd_b = model_mem[ab]; kb = model_set[ab]; end
        @(posedge clk);
        if (r) begin
            exp_qa = '0; exp_qb = '0; known_a = 1'b1; known_b = 1'b1;
        end else begin
            if (!cena && wena) begin exp_qa = rd_a; known_a = ka; end
            if (!cenb && wenb) begin exp_qb = rd_b; known_b = kb; end
            if (!cenb && !wenb && ab < DEPTH) begin
                model_mem[ab] = db; model_set[ab] = 1'b1;
            end
            if (!cena && !wena && aa < DEPTH) begin
                model_mem[aa] = da; model_set[aa] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 1, 1, 0, '0, 1, 1, 0, '0);
    endtask

    initial begin
        total_cnt = 0; pass_cnt = 0;
        known_a = 1'b0; known_b = 1'b0;
        exp_qa = '0; exp_qb = '0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0; model_set[i] = 1'b0;
        end
        rst = 1'b1; CENA = 1'b1; WENA = 1'b1; AA = '0; DA = '0;
        CENB = 1'b1; WENB = 1'b1; AB = '0; DB = '0;
        @(negedge clk);

        // Reset clears Q and swallows a write issued in the reset cycle
        step(1, 1, 1, 0, '0, 1, 1, 0, '0);
        check("reset_qa", QA, 64'h0);
        check("reset_qb", QB, 64'h0);
        step(0, 0, 0, 5, 64'h1234, 1, 1, 0, '0);
        step(0, 1, 1, 0, '0, 0, 1, 5, '0);
        check("preload_rd5", QB, 64'h1234);
        step(1, 0, 0, 5, 64'h9999, 0, 1, 5, '0);
        check("rst_rd_qb0", QB, 64'h0);
        step(0, 1, 1, 0, '0, 0, 1, 5, '0);
        check("post_rst_rd5", QB, 64'h1234);

        // Write then read with one-cycle latency; writer's Q untouched
        step(0, 0, 1, 5, '0, 1, 1, 0, '0);
        check("qa_rd5", QA, 64'h1234);
        step(0, 0, 0, 0, 64'hDEAD_BEEF_CAFE_F00D, 1, 1, 0, '0);
        check("qa_hold_on_wr", QA, 64'h1234);
        step(0, 1, 1, 0, '0, 0, 1, 0, '0);
        check("rd0_latency", QB, 64'hDEAD_BEEF_CAFE_F00D);

        // Read-before-write collision
        step(0, 0, 0, 7, 64'h1, 1, 1, 0, '0);
        step(0, 0, 0, 7, 64'h2, 0, 1, 7, '0);
        check("rbw_old", QB, 64'h1);
        step(0, 1, 1, 0, '0, 0, 1, 7, '0);
        check("rbw_new", QB, 64'h2);

        // Dual write collision: A wins
        step(0, 0, 0, 100, 64'hAAAA, 0, 0, 100, 64'hBBBB);
        step(0, 0, 1, 100, '0, 0, 1, 100, '0);
        check("dualwr_qa", QA, 64'hAAAA);
        check("dualrd_qb", QB, 64'hAAAA);

        // Independent writes at different addresses
        step(0, 0, 0, 200, 64'h1111, 0, 0, 201, 64'h2222);
        step(0, 0, 1, 201, '0, 0, 1, 200, '0);
        check("indep_qa", QA, 64'h2222);
        check("indep_qb", QB, 64'h1111);

        // Boundary addresses
        step(0, 0, 0, 1041, 64'h55, 1, 1, 0, '0);
        step(0, 1, 1, 0, '0, 0, 1, 1041, '0);
        check("rd_last", QB, 64'h55);
        step(0, 0, 0, 1042, 64'h77, 0, 0, 2047, 64'h88);
        step(0, 0, 1, 2047, '0, 0, 1, 1042, '0);
        check("oor_qa", QA, 64'h0);
        check("oor_qb", QB, 64'h0);
        step(0, 1, 1, 0, '0, 0, 1, 1041, '0);
        check("last_intact", QB, 64'h55);

        // FIFO streaming: B trails A by one cycle
        for (int i = 0; i <= 16; i++) begin
            step(0, (i < 16) ? 1'b0 : 1'b1, 0, i, DW'(i),
                    (i > 0) ? 1'b0 : 1'b1, 1, (i > 0) ? i - 1 : 0, '0);
            if (i > 0) check("stream", QB, DW'(i - 1));
        end
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i == 9) check("hold_15", QB, 64'd15);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
